// File: rtl/hangman_driver_if.sv
// Guess queue, game core link and result signals of the hangman driver.
interface hangman_driver_if;
    logic [4:0] letter_in;
    logic       letter_valid;
    logic       letter_ready;
    logic       letter_err;
    logic       new_game;
    logic [5:0] game_input;
    logic [6:0] game_output;
    logic       result_valid;
    logic       result_hit;
    logic [4:0] result_mask;
    logic [2:0] miss_count;
    logic       game_won;
    logic       game_lost;
    logic       busy;

    // Player/game-core side
    modport master (
        output letter_in, letter_valid, new_game, game_output,
        input  letter_ready, letter_err, game_input, result_valid, result_hit,
               result_mask, miss_count, game_won, game_lost, busy
    );

    // Driver side
    modport slave (
        input  letter_in, letter_valid, new_game, game_output,
        output letter_ready, letter_err, game_input, result_valid, result_hit,
               result_mask, miss_count, game_won, game_lost, busy
    );
endinterface

// File: rtl/hangman_driver.sv
// Hangman driver: queues guess letters, strobes them into the game core one at a time,
// waits for the core to settle and reports whether each guess revealed a new position.
module hangman_driver #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned START_CYCLES  = 3
) (
    input logic             clk,
    input logic             reset,
    hangman_driver_if.slave bus
);
    localparam int unsigned   PtrW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PtrW:0] Full       = FIFO_DEPTH[PtrW:0];
    localparam logic [3:0]    SettleLast = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0]    StartLast  = 4'(START_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle, StStart, StStartWait, StReady, StIssue, StSettle, StEval, StDone
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [4:0]      mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic [4:0]      pre_mask_q;
    logic [5:0]      game_input_q;
    logic [4:0]      result_mask_q;
    logic [2:0]      miss_q;
    logic            won_q, lost_q, err_q;

    logic full, empty, code_ok, push, pop, flush, hit, game_over;

    assign full      = (count_q == Full);
    assign empty     = (count_q == '0);
    assign code_ok   = (bus.letter_in <= 5'd25);
    assign hit       = |(bus.game_output[4:0] & ~pre_mask_q);
    assign game_over = bus.game_output[5] | bus.game_output[6];

    // A full queue still takes a letter in READY because the head leaves on the same edge
    assign bus.letter_ready = !full || (state_q == StReady);
    assign push = bus.letter_valid && bus.letter_ready && code_ok && !flush;

    assign bus.game_input   = game_input_q;
    assign bus.result_valid = (state_q == StEval);
    assign bus.result_hit   = (state_q == StEval) && hit;
    assign bus.result_mask  = result_mask_q;
    assign bus.miss_count   = miss_q;
    assign bus.game_won     = won_q;
    assign bus.game_lost    = lost_q;
    assign bus.letter_err   = err_q;
    // IDLE counts as not busy so the idle output matches the reset value
    assign bus.busy = !(state_q inside {StIdle, StReady, StDone});

    // Next-state, wait counter, queue pop and flush decisions
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.new_game) state_d = StStart;
            end
            StStart: begin
                state_d = StStartWait;
                cnt_d   = '0;
            end
            StStartWait: begin
                if (cnt_q == StartLast) state_d = StReady;
                else                    cnt_d   = cnt_q + 4'd1;
            end
            StReady: begin
                if (bus.new_game) begin
                    flush   = 1'b1;
                    state_d = StStart;
                end else if (!empty) begin
                    pop     = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StSettle;
                cnt_d   = '0;
            end
            StSettle: begin
                if (cnt_q == SettleLast) state_d = StEval;
                else                     cnt_d   = cnt_q + 4'd1;
            end
            StEval: begin
                if (game_over) begin
                    flush   = 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StReady;
                end
            end
            StDone: begin
                flush = 1'b1;
                if (bus.new_game) state_d = StStart;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and wait counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally since depth is a power of two
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Queue storage; a read of the head on a full push+pop edge sees the old entry
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.letter_in;
    end

    // Game core drive, guess evaluation and sticky game status
    always_ff @(posedge clk) begin
        if (!reset) begin
            game_input_q  <= '0;
            pre_mask_q    <= '0;
            result_mask_q <= '0;
            miss_q        <= '0;
            won_q         <= 1'b0;
            lost_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            err_q <= bus.letter_valid && !code_ok;
            // Strobe is high only while in START or ISSUE, each of which lasts one cycle
            if (state_d == StStart) game_input_q <= 6'h3f;
            else if (pop)           game_input_q <= {1'b1, mem[rd_ptr_q]};
            else                    game_input_q <= '0;
            if (pop) pre_mask_q <= bus.game_output[4:0];
            if (state_q == StStart) begin
                result_mask_q <= '0;
                miss_q        <= '0;
                won_q         <= 1'b0;
                lost_q        <= 1'b0;
            end else if (state_q == StEval) begin
                result_mask_q <= bus.game_output[4:0];
                if (!hit && miss_q != 3'd7) miss_q <= miss_q + 3'd1;
                won_q  <= bus.game_output[5];
                lost_q <= bus.game_output[6];
            end
        end
    end
endmodule

// File: tb/tb_hangman_driver.sv
// Self-checking bench for hangman_driver with a behavioural game core and scoreboard.
module tb_hangman_driver;
    localparam int unsigned Depth  = 4;
    localparam int unsigned Settle = 8;
    localparam int unsigned StartC = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    hangman_driver_if bus_if ();

    hangman_driver #(
        .FIFO_DEPTH   (Depth),
        .SETTLE_CYCLES(Settle),
        .START_CYCLES (StartC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    // Game core: secret word, position i maps to mask bit 4-i; loses after 7 absent letters
    logic [4:0] word [5];
    logic [4:0] core_mask  = '0;
    int         core_wrong = 0;

    function automatic logic [4:0] reveal(input logic [4:0] g);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) if (word[i] == g) r[4-i] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus_if.game_input == 6'h3f) begin
            core_mask  <= '0;
            core_wrong <= 0;
        end else if (bus_if.game_input[5] === 1'b1) begin
            core_mask <= core_mask | reveal(bus_if.game_input[4:0]);
            if (reveal(bus_if.game_input[4:0]) == '0) core_wrong <= core_wrong + 1;
        end
    end

    assign bus_if.game_output = {core_wrong >= 7, core_mask == 5'h1f, core_mask};

    typedef struct {
        logic [4:0] code;
        logic       hit;
        logic [4:0] mask;
        logic [2:0] miss;
        logic       won;
        logic       lost;
        int         lat;
    } res_t;

    typedef struct {
        logic [4:0] code;
        bit         ready;
        bit         push;
    } vec_t;

    res_t       res_q[$];
    res_t       cur;
    int         acc_q[$];
    vec_t       vecs[9];
    bit         post_eval = 0;
    bit         prev_strobe = 0;
    int         cyc = 0, issue_cyc = 0, n_issue = 0, strobe_twice = 0;
    logic [4:0] last_code = '0;
    int         errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock and record strobes and results, sampling 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (post_eval) begin
            cur.mask = bus_if.result_mask;
            cur.miss = bus_if.miss_count;
            cur.won  = bus_if.game_won;
            cur.lost = bus_if.game_lost;
            res_q.push_back(cur);
            post_eval = 0;
        end
        if (bus_if.game_input[5] === 1'b1 && prev_strobe) strobe_twice++;
        prev_strobe = (bus_if.game_input[5] === 1'b1);
        if (bus_if.game_input[5] === 1'b1 && bus_if.game_input != 6'h3f) begin
            n_issue++;
            last_code = bus_if.game_input[4:0];
            issue_cyc = cyc;
        end
        if (bus_if.result_valid === 1'b1) begin
            cur.code  = last_code;
            cur.hit   = bus_if.result_hit;
            cur.lat   = cyc - issue_cyc;
            post_eval = 1;
        end
    endtask

    task automatic offer(input logic [4:0] code, output bit acc);
        bus_if.letter_in    = code;
        bus_if.letter_valid = 1'b1;
        acc = bus_if.letter_ready && (code <= 5'd25);
        tick();
        bus_if.letter_valid = 1'b0;
        chk("letter_err", bus_if.letter_err, code > 5'd25);
    endtask

    task automatic offer_wait(input logic [4:0] code);
        bit acc;
        acc = 0;
        for (int i = 0; i < 400 && !acc; i++) begin
            if (bus_if.letter_ready) offer(code, acc);
            else tick();
        end
        chk("offer_accepted", acc, 1);
        acc_q.push_back(code);
    endtask

    task automatic wait_quiet();
        int quiet;
        quiet = 0;
        for (int i = 0; i < 3000 && quiet < 3; i++) begin
            tick();
            quiet = bus_if.busy ? 0 : quiet + 1;
        end
        chk("quiet_timeout", quiet >= 3, 1);
    endtask

    task automatic wait_issue();
        int n0;
        n0 = n_issue;
        for (int i = 0; i < 50 && n_issue == n0; i++) tick();
        chk("issue_timeout", n_issue > n0, 1);
    endtask

    task automatic start_game();
        res_q.delete();
        bus_if.new_game = 1'b1;
        tick();
        bus_if.new_game = 1'b0;
    endtask

    task automatic chk_reset(input string n);
        chk({n, "_game_input"}, bus_if.game_input, 0);
        chk({n, "_result_valid"}, bus_if.result_valid, 0);
        chk({n, "_result_hit"}, bus_if.result_hit, 0);
        chk({n, "_result_mask"}, bus_if.result_mask, 0);
        chk({n, "_miss_count"}, bus_if.miss_count, 0);
        chk({n, "_game_won"}, bus_if.game_won, 0);
        chk({n, "_game_lost"}, bus_if.game_lost, 0);
        chk({n, "_letter_err"}, bus_if.letter_err, 0);
        chk({n, "_busy"}, bus_if.busy, 0);
    endtask

    // Reference: play the accepted letters in order against the word until the game ends
    task automatic check_results(input string name);
        logic [4:0] m, nm, g;
        int         wrong, miss, n;
        bit         over, hit;
        m = '0; wrong = 0; miss = 0; n = 0; over = 0;
        foreach (acc_q[j]) begin
            if (!over) begin
                g   = 5'(acc_q[j]);
                nm  = m | reveal(g);
                hit = (nm != m);
                if (reveal(g) == '0) wrong++;
                if (!hit && miss < 7) miss++;
                m    = nm;
                over = (m == 5'h1f) || (wrong >= 7);
                if (n < res_q.size()) begin
                    chk({name, "_code"}, res_q[n].code, g);
                    chk({name, "_hit"}, res_q[n].hit, hit);
                    chk({name, "_mask"}, res_q[n].mask, m);
                    chk({name, "_miss"}, res_q[n].miss, miss);
                    chk({name, "_won"}, res_q[n].won, m == 5'h1f);
                    chk({name, "_lost"}, res_q[n].lost, wrong >= 7);
                    chk({name, "_latency"}, res_q[n].lat, Settle + 1);
                end
                n++;
            end
        end
        chk({name, "_count"}, res_q.size(), n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bit         acc;
        int         n0, nres;
        logic [4:0] code;

        bus_if.letter_in    = '0;
        bus_if.letter_valid = 1'b0;
        bus_if.new_game     = 1'b0;
        word = '{5'd13, 5'd14, 5'd19, 5'd17, 5'd4};

        // Reset values
        reset = 1'b0;
        repeat (2) tick();
        chk_reset("rst");
        reset = 1'b1;
        tick();
        chk("rst_ready", bus_if.letter_ready, 1);

        // Queue fill and code validation in IDLE: code, ready afterwards, pushed
        vecs[0] = '{5'd27, 1'b1, 1'b0};
        vecs[1] = '{5'd3,  1'b1, 1'b1};
        vecs[2] = '{5'd31, 1'b1, 1'b0};
        vecs[3] = '{5'd25, 1'b1, 1'b1};
        vecs[4] = '{5'd26, 1'b1, 1'b0};
        vecs[5] = '{5'd0,  1'b1, 1'b1};
        vecs[6] = '{5'd7,  1'b0, 1'b1};
        vecs[7] = '{5'd9,  1'b0, 1'b0};
        vecs[8] = '{5'd30, 1'b0, 1'b0};
        acc_q.delete();
        foreach (vecs[i]) begin
            offer(vecs[i].code, acc);
            chk("tbl_ready", bus_if.letter_ready, vecs[i].ready);
            if (vecs[i].push) acc_q.push_back(vecs[i].code);
        end

        // Start sequence, then the four queued misses are played
        start_game();
        chk("start_strobe", bus_if.game_input, 6'h3f);
        for (int k = 0; k < StartC; k++) begin
            tick();
            chk("start_wait_input", bus_if.game_input, 0);
            chk("start_wait_busy", bus_if.busy, 1);
        end
        tick();
        chk("ready_busy", bus_if.busy, 0);
        wait_quiet();
        check_results("tbl");
        chk("tbl_miss_count", bus_if.miss_count, 4);

        // Winning game "notre" started from READY
        acc_q.delete();
        start_game();
        offer_wait(5'd13);
        offer_wait(5'd14);
        offer_wait(5'd19);
        offer_wait(5'd17);
        offer_wait(5'd4);
        wait_quiet();
        check_results("notre");
        chk("notre_won", bus_if.game_won, 1);
        chk("notre_mask", bus_if.result_mask, 5'h1f);
        n0 = n_issue;
        offer(5'd1, acc);
        chk("done_accept", acc, 1);
        repeat (20) tick();
        chk("done_discard", n_issue, n0);

        // Losing game: nine 'a' guesses, loss on the seventh, the rest flushed
        acc_q.delete();
        start_game();
        repeat (9) offer_wait(5'd0);
        wait_quiet();
        check_results("lost");
        chk("lost_flag", bus_if.game_lost, 1);
        chk("lost_miss", bus_if.miss_count, 7);
        acc_q.delete();
        n0 = n_issue;
        start_game();
        repeat (30) tick();
        chk("lost_flushed", n_issue, n0);

        // Fill the queue while a guess settles; push alongside the next pop
        offer(5'd13, acc);
        chk("fill_first", acc, 1);
        acc_q.push_back(13);
        wait_issue();
        tick();
        foreach (vecs[i]) if (i < 4) begin
            code = (i == 3) ? 5'd5 : 5'(i + 1);
            offer(code, acc);
            chk("fill_push", acc, 1);
            acc_q.push_back(code);
        end
        chk("full_ready", bus_if.letter_ready, 0);
        offer(5'd6, acc);
        chk("full_blocked", acc, 0);
        for (int i = 0; i < 50 && bus_if.busy; i++) tick();
        chk("full_reach_ready", bus_if.busy, 0);
        offer(5'd14, acc);
        chk("full_push_pop", acc, 1);
        acc_q.push_back(14);
        wait_quiet();
        check_results("full");

        // Reset on the third SETTLE cycle aborts the guess and empties the queue
        offer(5'd23, acc);
        wait_issue();
        offer(5'd24, acc);
        offer(5'd22, acc);
        tick();
        nres  = res_q.size();
        reset = 1'b0;
        tick();
        chk_reset("abort");
        reset = 1'b1;
        tick();
        chk("abort_ready", bus_if.letter_ready, 1);
        repeat (Settle + 4) tick();
        chk("abort_no_result", res_q.size(), nres);
        n0 = n_issue;
        start_game();
        repeat (30) tick();
        chk("abort_queue_empty", n_issue, n0);

        // Randomized games against the reference
        for (int g = 0; g < 8; g++) begin
            for (int i = 0; i < 5; i++) word[i] = 5'($urandom_range(0, 7));
            acc_q.delete();
            start_game();
            repeat (14) begin
                repeat ($urandom_range(0, 3)) tick();
                if ($urandom_range(0, 5) == 0) code = 5'($urandom_range(26, 31));
                else code = 5'($urandom_range(0, 9));
                offer(code, acc);
                if (acc) acc_q.push_back(code);
            end
            wait_quiet();
            check_results("rand");
        end

        chk("strobe_twice", strobe_twice, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
